// File: rtl/tb_vector_player.sv
// Test-vector sequencer: replays a loaded table of stimulus rows (with clock-pulse bits) onto a DUT
// and checks its outputs with per-bit don't-care. Option: TB_VECTOR_PLAYER_STOP_ON_FAIL_EN ends the run at the first failing row.
module tb_vector_player #(
    parameter int N_IN   = 9,
    parameter int N_OUT  = 5,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter int SETTLE = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        we,
    input  logic [ADDR_W-1:0]           waddr,
    input  logic [2*N_IN+2*N_OUT-1:0]   wdata,
    input  logic [ADDR_W:0]             num_vec,
    input  logic                        start,
    input  logic [N_OUT-1:0]            dut_out,
    output logic [N_IN-1:0]             dut_in,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic [ADDR_W:0]             err_count,
    output logic [ADDR_W-1:0]           fail_idx
);
    // state    | meaning
    // IDLE     | waiting for start; table writable
    // FETCH    | registered read of row 0 before the first drive phase
    // DRIVE    | row values applied, pulse bits low
    // PULSE_HI | pulse bits high, other bits at row values
    // PULSE_LO | pulse bits low again
    // CHECK    | compare DUT outputs; doubles as the fetch cycle of the next row
    // FIN      | done pulse, pass result presented
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_DRIVE = 3'd2;
    localparam logic [2:0] S_PH    = 3'd3;
    localparam logic [2:0] S_PL    = 3'd4;
    localparam logic [2:0] S_CHECK = 3'd5;
    localparam logic [2:0] S_FIN   = 3'd6;

    localparam int W = 2*N_IN + 2*N_OUT;
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);
`ifdef TB_VECTOR_PLAYER_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    logic [2:0]        state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W:0]   nv_q;
    logic [ADDR_W:0]   nv_clamp;
    logic [3:0]        cnt;
    logic              pass_q;
    logic [N_IN-1:0]   hold;
    logic [W-1:0]      mem [DEPTH];
    logic [W-1:0]      row_q;
    logic [N_IN-1:0]   r_pulse;
    logic [N_IN-1:0]   r_val;
    logic [N_OUT-1:0]  r_care;
    logic [N_OUT-1:0]  r_exp;
    logic              mism;
    logic              last_row;

    assign {r_pulse, r_val, r_care, r_exp} = row_q;
    assign mism     = |((dut_out ^ r_exp) & r_care);
    assign last_row = ({1'b0, idx} + (ADDR_W+1)'(1)) == nv_q;
    assign nv_clamp = (num_vec > DEPTH_V) ? DEPTH_V : num_vec;
    assign rd_addr  = (state == S_CHECK) ? idx + ADDR_W'(1) : idx;

    assign busy = (state != S_IDLE);
    assign done = (state == S_FIN);
    assign pass = (state == S_FIN) ? (err_count == '0) : pass_q;

    always_comb begin
        dut_in = hold;
        case (state)
            S_DRIVE, S_PL: dut_in = r_val & ~r_pulse;
            S_PH:          dut_in = r_val | r_pulse;
            default:       dut_in = hold;
        endcase
    end

    // Table RAM is not reset; writes are locked out for the whole run.
    always_ff @(posedge clk) begin
        if (we && state == S_IDLE)
            mem[waddr] <= wdata;
        row_q <= mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            nv_q      <= '0;
            cnt       <= '0;
            err_count <= '0;
            fail_idx  <= '0;
            pass_q    <= 1'b0;
            hold      <= '0;
        end else begin
            hold <= dut_in;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        err_count <= '0;
                        fail_idx  <= '0;
                        pass_q    <= 1'b0;
                        idx       <= '0;
                        nv_q      <= nv_clamp;
                        state     <= (nv_clamp == '0) ? S_FIN : S_FETCH;
                    end
                end
                S_FETCH: begin
                    cnt   <= 4'(SETTLE);
                    state <= S_DRIVE;
                end
                S_DRIVE: begin
                    if (cnt == 4'd0) begin
                        cnt   <= 4'(SETTLE);
                        state <= (r_pulse != '0) ? S_PH : S_CHECK;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_PH: begin
                    if (cnt == 4'd0) begin
                        cnt   <= 4'(SETTLE);
                        state <= S_PL;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_PL: begin
                    if (cnt == 4'd0)
                        state <= S_CHECK;
                    else
                        cnt <= cnt - 4'd1;
                end
                S_CHECK: begin
                    if (mism) begin
                        if (err_count != '1)
                            err_count <= err_count + (ADDR_W+1)'(1);
                        if (err_count == '0)
                            fail_idx <= idx;
                    end
                    if (last_row || (STOP_ON_FAIL && mism)) begin
                        state <= S_FIN;
                    end else begin
                        idx   <= idx + ADDR_W'(1);
                        cnt   <= 4'(SETTLE);
                        state <= S_DRIVE;
                    end
                end
                S_FIN: begin
                    pass_q <= (err_count == '0);
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tb_vector_player.sv
// Bench for tb_vector_player: a 74162 decade-counter model acts as the device, and a row-level
// reference predicts the per-cycle pin/handshake trace and the pass/error results.
module tb_tb_vector_player;
    localparam int N_IN   = 9;
    localparam int N_OUT  = 5;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;
    localparam int SETTLE = 1;
    localparam int W      = 2*N_IN + 2*N_OUT;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 we;
    logic [ADDR_W-1:0]    waddr;
    logic [W-1:0]         wdata;
    logic [ADDR_W:0]      num_vec;
    logic                 start;
    logic [N_OUT-1:0]     dut_out;
    logic [N_IN-1:0]      dut_in;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [ADDR_W:0]      err_count;
    logic [ADDR_W-1:0]    fail_idx;

    int                   n_chk = 0;
    int                   n_pass = 0;
    logic [W-1:0]         tbl [DEPTH];
    logic [N_IN-1:0]      mdl_hold;
    logic [3:0]           dev_q = 4'd0;

    tb_vector_player #(
        .N_IN(N_IN), .N_OUT(N_OUT), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .SETTLE(SETTLE)
    ) u_dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .num_vec(num_vec), .start(start), .dut_out(dut_out), .dut_in(dut_in),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count), .fail_idx(fail_idx)
    );

    always #5 clk = ~clk;

    // Pins: [8]=CLK [7]=~CLR [6]=~LD [5]=ENT [4]=ENP [3:0]=DCBA; outputs {RCO, QD..QA}.
    function automatic logic [3:0] ctr_next(input logic [3:0] q, input logic [N_IN-1:0] pins);
        if (!pins[7])                 return 4'd0;
        else if (!pins[6])            return pins[3:0];
        else if (pins[5] && pins[4])  return (q == 4'd9) ? 4'd0 : q + 4'd1;
        else                          return q;
    endfunction

    function automatic logic [N_OUT-1:0] dev_out(input logic [3:0] q, input logic [N_IN-1:0] pins);
        return {pins[5] && (q == 4'd9), q};
    endfunction

    always @(posedge dut_in[8]) dev_q <= ctr_next(dev_q, dut_in);
    assign dut_out = dev_out(dev_q, dut_in);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, got, want);
    endtask

    function automatic logic [W-1:0] mk_row(input logic [N_IN-1:0] p, input logic [N_IN-1:0] v,
                                            input logic [N_OUT-1:0] c, input logic [N_OUT-1:0] e);
        return {p, v, c, e};
    endfunction

    task automatic write_row(input int a, input logic [W-1:0] d);
        @(negedge clk);
        we = 1'b1; waddr = ADDR_W'(a); wdata = d;
        tbl[a] = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    // Load 9, then ten counting clocks: 0,1,..,9 with RCO only at 9.
    task automatic load_count();
        write_row(0, mk_row(9'h100, 9'b0_1_0_1_1_1001, 5'h1F, {1'b1, 4'd9}));
        for (int r = 1; r <= 10; r++)
            write_row(r, mk_row(9'h100, 9'b0_1_1_1_1_0000, 5'h1F, {r == 10, 4'(r - 1)}));
    endtask

    task automatic rand_table();
        logic [3:0] q;
        q = 4'd0;
        for (int r = 0; r < DEPTH; r++) begin
            logic [N_IN-1:0] v, p;
            logic [N_OUT-1:0] o, c, e;
            if (r == 0) begin
                v = {1'b0, 1'b1, 1'b0, 2'($urandom), 4'($urandom_range(0, 9))};
                p = 9'h100;
            end else begin
                v = {1'b0, ($urandom % 8) != 0, ($urandom % 4) != 0, 2'($urandom), 4'($urandom_range(0, 9))};
                p = {($urandom % 10) < 7, 4'($urandom), 4'b0000};
            end
            if (p[8]) q = ctr_next(q, v | p);
            o = dev_out(q, v & ~p);
            c = 5'($urandom);
            e = (($urandom % 4) == 0) ? o ^ 5'($urandom_range(1, 31)) : o;
            write_row(r, mk_row(p, v, c, e));
        end
    endtask

    // Predict the run from the table rows, then replay it and compare cycle by cycle.
    task automatic do_run(input int nv_raw, input bit poke);
        logic [N_IN+1:0] tr[$];
        logic [N_IN-1:0] h;
        logic [3:0] q;
        int nv, err, fidx, pk;
        nv = (nv_raw > DEPTH) ? DEPTH : nv_raw;
        h = mdl_hold; q = 4'd0; err = 0; fidx = 0;
        if (nv > 0) tr.push_back({2'b10, h});
        for (int r = 0; r < nv; r++) begin
            logic [N_IN-1:0] v, p, lo, hi;
            logic [N_OUT-1:0] c, e, o;
            {p, v, c, e} = tbl[r];
            lo = v & ~p;
            hi = v | p;
            repeat (SETTLE + 1) tr.push_back({2'b10, lo});
            if (p != '0) begin
                repeat (SETTLE + 1) tr.push_back({2'b10, hi});
                repeat (SETTLE + 1) tr.push_back({2'b10, lo});
                if (p[8]) q = ctr_next(q, hi);
            end
            tr.push_back({2'b10, lo});
            h = lo;
            o = dev_out(q, lo);
            if (((o ^ e) & c) != '0) begin
                if (err == 0) fidx = r;
                err++;
`ifdef TB_VECTOR_PLAYER_STOP_ON_FAIL_EN
                break;
`endif
            end
        end
        tr.push_back({2'b11, h});
        tr.push_back({2'b00, h});
        mdl_hold = h;
        pk = poke ? int'($urandom_range(0, tr.size() - 2)) : -1;

        @(negedge clk);
        num_vec = (ADDR_W+1)'(nv_raw);
        start = 1'b1;
        @(negedge clk);
        for (int i = 0; i < tr.size(); i++) begin
            if (i == pk) begin
                start = 1'b1; we = 1'b1; waddr = '0; wdata = W'($urandom);
            end else begin
                start = 1'b0; we = 1'b0;
            end
            chk($sformatf("trace[%0d]", i), {busy, done, dut_in}, tr[i]);
            @(negedge clk);
        end
        start = 1'b0; we = 1'b0;
        chk("err_count", err_count, err);
        chk("fail_idx", fail_idx, fidx);
        chk("pass", pass, err == 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rises, seen_done, want_err;
        logic prev;
        rst = 1'b1; we = 1'b0; start = 1'b0; waddr = '0; wdata = '0; num_vec = '0;
        mdl_hold = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err_count, 0);
        chk("rst_fidx", fail_idx, 0);
        chk("rst_dut_in", dut_in, 0);
        rst = 1'b0;

        // 74162 load of 0101 with a clock pulse, QD..QA cared
        write_row(0, mk_row(9'h100, 9'b0_1_0_0_0_0101, 5'b01111, 5'b00101));
        do_run(1, 1'b0);
        chk("load_pass", pass, 1);

        load_count();
        do_run(11, 1'b0);
        chk("count_err", err_count, 0);
        write_row(3, tbl[3] ^ W'(1));
        do_run(11, 1'b0);
        chk("corrupt_err", err_count, 1);
        chk("corrupt_fidx", fail_idx, 3);
        chk("corrupt_pass", pass, 0);

        do_run(0, 1'b0);
        chk("empty_pass", pass, 1);

        // reset during the first PULSE_HI cycle of row 2
        @(negedge clk);
        num_vec = 7'(11); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rises = 0; seen_done = 0; prev = dut_in[8];
        for (int i = 0; i < 200 && rises < 3; i++) begin
            if (done) seen_done = 1;
            if (dut_in[8] && !prev) rises++;
            prev = dut_in[8];
            if (rises < 3) @(negedge clk);
        end
        chk("rst_wait_pulse", rises, 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_dut_in", dut_in, 0);
        chk("midrst_err", err_count, 0);
        chk("midrst_done", done | seen_done, 0);
        mdl_hold = '0;
        do_run(11, 1'b0);

        write_row(3, tbl[3] ^ W'(1));
        write_row(1, tbl[1] ^ W'(1));
        write_row(4, tbl[4] ^ W'(1));
        do_run(11, 1'b0);
`ifdef TB_VECTOR_PLAYER_STOP_ON_FAIL_EN
        want_err = 1;
`else
        want_err = 2;
`endif
        chk("two_bad_err", err_count, want_err);
        chk("two_bad_fidx", fail_idx, 1);

        // START and WE while busy must not disturb the run or the table
        load_count();
        do_run(11, 1'b1);
        do_run(11, 1'b0);
        chk("readback_pass", pass, 1);

        for (int k = 0; k < 6; k++) begin
            rand_table();
            do_run((k == 0) ? int'($urandom_range(33, 63)) : int'($urandom_range(1, 32)), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
